fir_mac_seq: RTL

- Downstream consumer of the tap shift register. Snapshots the NUM_TAPS parallel tap outputs plus a coefficient set on a valid/ready handshake.
- Computes y = sum(c[i]*x[i]) with one time-multiplexed signed multiplier, one tap per cycle.
- Presents the scaled DATA_WIDTH result on a valid/ready output toward the sensor-side consumer.

---
 rtl/fir_pkg.sv | 32 +++
 rtl/fir_mac_unit.sv | 37 +++
 rtl/fir_mac_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the sequential FIR multiply-accumulate block.
// Optional build macro FIR_SAT_EN: compiles the saturate() helper.
package fir_pkg;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    // Full-precision product width plus headroom for NUM_TAPS additions.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned nt);
        return 2 * dw + $clog2(nt);
    endfunction

`ifdef FIR_SAT_EN
    // Working width for saturate(); wide enough for any practical accumulator.
    localparam int unsigned SatW = 64;

    // Clamp v to the signed range of a dw-bit value.
    function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] v,
                                                        input int unsigned dw);
        logic signed [SatW-1:0] max_v;
        logic signed [SatW-1:0] min_v;
        max_v = $signed((SatW'(1) << (dw - 1)) - SatW'(1));
        min_v = ~max_v;
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction
`endif

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiplier feeding an accumulator register with clear and enable.
module fir_mac_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 35
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] c,
    output logic signed [ACC_WIDTH-1:0]  acc_next
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    // Full-precision product, sign-extended, added to the running sum.
    always_comb begin
        prod     = x * c;
        prod_ext = ACC_WIDTH'(prod);
        acc_next = acc_q + prod_ext;
    end

    // Accumulator register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR: snapshots taps/coefs, accumulates one term per cycle, then
// presents the scaled result on a valid/ready output.
// Optional build macro FIR_SAT_EN: saturate instead of wrap when narrowing.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_TAPS   = 8,
    parameter int unsigned COEF_FRAC  = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  taps_in,
    input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  coef_in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic signed [DATA_WIDTH-1:0]         y_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy
);

    localparam int unsigned AccW = acc_width(DATA_WIDTH, NUM_TAPS);
    localparam int unsigned IdxW = $clog2(NUM_TAPS);

    state_e                               state_q, state_d;
    logic [IdxW-1:0]                      idx_q, idx_d;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  snap_x_q;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  snap_c_q;
    logic                                 load;
    logic                                 acc_clr;
    logic                                 acc_en;
    logic                                 fin;
    logic signed [DATA_WIDTH-1:0]         x_sel;
    logic signed [DATA_WIDTH-1:0]         c_sel;
    logic signed [AccW-1:0]               acc_next;
    logic signed [DATA_WIDTH-1:0]         y_d;
    logic                                 out_valid_q;
    logic signed [DATA_WIDTH-1:0]         y_q;

    // Next-state, handshake and datapath control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        load     = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        fin      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    acc_clr = 1'b1;
                    idx_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                busy   = 1'b1;
                acc_en = 1'b1;
                idx_d  = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NUM_TAPS - 1)) begin
                    fin     = 1'b1;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Accepting on the DONE exit edge removes the idle bubble.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        acc_clr = 1'b1;
                        idx_d   = '0;
                        state_d = StMac;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and tap index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Snapshot registers decouple the result from later input changes.
    always_ff @(posedge clk) begin
        if (load) begin
            snap_x_q <= taps_in;
            snap_c_q <= coef_in;
        end
    end

    // Select the current tap/coefficient pair for the shared multiplier.
    always_comb begin
        x_sel = $signed(snap_x_q[idx_q]);
        c_sel = $signed(snap_c_q[idx_q]);
    end

    fir_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (AccW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .en       (acc_en),
        .x        (x_sel),
        .c        (c_sel),
        .acc_next (acc_next)
    );

    // Scale the final sum (including the last term) down to the output width.
    always_comb begin
`ifdef FIR_SAT_EN
        y_d = DATA_WIDTH'(saturate(SatW'(acc_next >>> COEF_FRAC), DATA_WIDTH));
`else
        y_d = DATA_WIDTH'(acc_next >>> COEF_FRAC);
`endif
    end

    // Registered output stage; y_out holds its value until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else if (fin) begin
            out_valid_q <= 1'b1;
            y_q         <= y_d;
        end else if (state_q == StDone && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;

endmodule
